load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Multi-cycle data-memory access stage directly downstream of the ALU: takes the ALU result as the
//  effective address, drives a req/ack data-memory bus, and returns load data to writeback.
//  Handles byte-lane selection and byte enables, load sign/zero-extension and a bus timeout.
//  Holds o_busy to stall the core while an access is in flight.
// PARAMETERS
//  TIMEOUT_CYCLES  255  WAIT cycles without i_mem_ack before aborting with o_err; 0 = never time out
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rst_n       in   1   asynchronous active-low reset
//  i_req         in   1   access request, sampled only in IDLE
//  i_we          in   1   1 = store, 0 = load
//  i_funct3      in   3   RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  i_addr        in   32  effective address (ALU result)
//  i_wdata       in   32  store data (rs2), right-aligned
//  o_busy        out  1   high while state != IDLE
//  o_done        out  1   one-cycle completion pulse
//  o_rdata       out  32  extended load data, valid while o_done=1 and i_we was 0
//  o_err         out  1   valid with o_done: illegal funct3, timeout or (optional) misaligned access
//  o_mem_req     out  1   bus request, held until ack or abort
//  o_mem_we      out  1   bus write
//  o_mem_addr    out  32  word address {addr[31:2],2'b00}
//  o_mem_be      out  4   byte enables; loads drive 4'b1111
//  o_mem_wdata   out  32  store data replicated onto the byte lanes
//  i_mem_ack     in   1   bus ack; read data valid in the same cycle
//  i_mem_rdata   in   32  bus read word
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; timeout counter 0. Reset mid-access drops o_mem_req at once
//  and produces no o_done.
//  FSM: IDLE -> WAIT on i_req when the request is legal. IDLE -> DONE with err=1 when illegal.
//  WAIT -> DONE on i_mem_ack, or when count == TIMEOUT_CYCLES-1 (err=1). DONE -> IDLE unconditionally.
//  Request capture: i_we, i_funct3, i_addr and i_wdata are registered in IDLE. Inputs are ignored
//  in WAIT and DONE, and an i_req asserted during DONE is dropped.
//  Bus outputs: registered; o_mem_req=1 during every WAIT cycle and 0 otherwise.
//  Minimum latency: req at cycle 0, o_mem_req at cycle 1, ack at cycle 1, o_done at cycle 2.
//  Timeout counter: cleared on entry to WAIT; increments each WAIT cycle without ack.
//  Ack and timeout in the same cycle: ack wins, err=0.
//  Illegal funct3: loads 011/110/111; stores any value other than 000/001/010.
//  Store BE: SB 4'b0001<<addr[1:0]; SH addr[1] ? 4'b1100 : 4'b0011; SW 4'b1111.
//  Store wdata: SB {4{b}}; SH {2{h}}; SW the word as given.
//  Load extraction: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
//  Load extension: sign-extend for LB/LH, zero-extend for LBU/LHU.
//  o_rdata is registered on ack and forced to 0 on any err. o_rdata holds its value after
//  o_done until the next completion.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, is illegal.
//    It follows the IDLE->DONE err=1 path, issues no bus request and leaves memory unchanged.
//  MISALIGN_TRAP_EN undefined: low offset bits are truncated (H: addr[0]=0; W: addr[1:0]=0) and the
//    access proceeds normally; misalignment never sets o_err.
// STRUCTURE
//  lsu_pkg: typedef enum logic [1:0] {IDLE, WAIT, DONE} lsu_state_t; localparams F3_B/F3_H/F3_W/
//    F3_BU/F3_HU; function is_legal(we, funct3).
//  Sub-module lsu_align (combinational): addr[1:0] + funct3 -> o_mem_be and o_mem_wdata lanes,
//    and rdata -> extended load value. Instantiated once.
//  Top level holds the FSM, the request registers and the timeout counter.
// TESTING
//  LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF -> o_done at cycle 2, o_rdata=0xDEADBEEF, err=0.
//  LB addr 0x103, rdata 0x80FF_FFFF -> o_rdata=0xFFFFFF80; LBU same -> 0x00000080.
//  LH addr 0x102, rdata 0x8001_0000 -> o_rdata=0xFFFF8001; LHU same -> 0x00008001.
//  SB addr 0x202, wdata 0x12345678 -> o_mem_addr=0x200, be=4'b0100, o_mem_wdata=0x78787878, o_mem_we=1.
//  SH addr 0x200, wdata 0x0000ABCD -> be=4'b0011, o_mem_wdata=0xABCDABCD.
//  No ack, TIMEOUT_CYCLES=4 -> o_mem_req high 4 cycles, then o_done=1, o_err=1, o_rdata=0.
//  Store with funct3=100 -> o_done next cycle with err=1 and no o_mem_req.
//  SW addr 0x101 with MISALIGN_TRAP_EN -> err=1, no o_mem_req; without it -> o_mem_addr=0x100, be=4'b1111.
//  i_rst_n low during WAIT -> o_mem_req=0 asynchronously, no o_done.
//  After release, a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size/sign encodings follow the RV32I funct3 field.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic is_legal(
    input logic       we,
    input logic [2:0] funct3
  );
    logic ok;
    ok = (funct3 == F3_B) || (funct3 == F3_H) ||
         (funct3 == F3_W);
    if (!we)
      ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and lane replication,
// load byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic        sx;

  always_comb begin
    byte_v = i_rdata[{i_off, 3'b000} +: 8];
    half_v = i_rdata[{i_off[1], 4'b0000} +: 16];
    sx     = ~i_funct3[2];
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    o_rdata = i_rdata;
    case (i_funct3 & 3'b011)
      F3_B: begin
        o_be    = 4'b0001 << i_off;
        o_wdata = {4{i_wdata[7:0]}};
        o_rdata = {{24{sx & byte_v[7]}}, byte_v};
      end
      F3_H: begin
        o_be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
        o_rdata = {{16{sx & half_v[15]}}, half_v};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage with req/ack bus and timeout.
// Define MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [31:0] TO_LAST =
    (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  lsu_state_t  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mreq_q, mreq_d;
  logic        mwe_q, mwe_d;
  logic [31:0] maddr_q, maddr_d;
  logic [3:0]  mbe_q, mbe_d;
  logic [31:0] mwd_q, mwd_d;

  logic        idle;
  logic [1:0]  off_sel;
  logic [2:0]  f3_sel;
  logic [3:0]  al_be;
  logic [31:0] al_wd;
  logic [31:0] al_rd;
  logic        req_ok;
  logic        to_hit;

  assign idle    = (state_q == IDLE);
  assign off_sel = idle ? i_addr[1:0] : off_q;
  assign f3_sel  = idle ? i_funct3 : f3_q;

  lsu_align u_align (
    .i_off    (off_sel),
    .i_funct3 (f3_sel),
    .i_wdata  (i_wdata),
    .i_rdata  (i_mem_rdata),
    .o_be     (al_be),
    .o_wdata  (al_wd),
    .o_rdata  (al_rd)
  );

  always_comb begin
    req_ok = is_legal(i_we, i_funct3);
`ifdef MISALIGN_TRAP_EN
    if (i_funct3[1:0] == 2'b01 && i_addr[0])
      req_ok = 1'b0;
    if (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00)
      req_ok = 1'b0;
`endif
  end

  assign to_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = rdata_q;
    mreq_d  = 1'b0;
    mwe_d   = 1'b0;
    maddr_d = 32'd0;
    mbe_d   = 4'd0;
    mwd_d   = 32'd0;
    unique case (state_q)
      IDLE: if (i_req) begin
        we_d  = i_we;
        f3_d  = i_funct3;
        off_d = i_addr[1:0];
        if (req_ok) begin
          state_d = WAIT;
          cnt_d   = 32'd0;
          mreq_d  = 1'b1;
          mwe_d   = i_we;
          maddr_d = {i_addr[31:2], 2'b00};
          mbe_d   = i_we ? al_be : 4'b1111;
          mwd_d   = i_we ? al_wd : 32'd0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end
      end
      WAIT: begin
        // ack takes priority over a timeout in the same cycle
        if (i_mem_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          if (!we_q)
            rdata_d = al_rd;
        end else if (to_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = 32'd0;
        end else begin
          cnt_d   = cnt_q + 32'd1;
          mreq_d  = 1'b1;
          mwe_d   = mwe_q;
          maddr_d = maddr_q;
          mbe_d   = mbe_q;
          mwd_d   = mwd_q;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      cnt_q   <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      mreq_q  <= 1'b0;
      mwe_q   <= 1'b0;
      maddr_q <= 32'd0;
      mbe_q   <= 4'd0;
      mwd_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      mreq_q  <= mreq_d;
      mwe_q   <= mwe_d;
      maddr_q <= maddr_d;
      mbe_q   <= mbe_d;
      mwd_q   <= mwd_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_err       = err_q;
  assign o_rdata     = rdata_q;
  assign o_mem_req   = mreq_q;
  assign o_mem_we    = mwe_q;
  assign o_mem_addr  = maddr_q;
  assign o_mem_be    = mbe_q;
  assign o_mem_wdata = mwd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed spec cases plus random
// accesses against an arithmetic reference model.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk;
  logic        rst_n;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_rdata;
  logic        o_err;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int ntot  = 0;
  int npass = 0;
  int nfail = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (i_req),
    .i_we        (i_we),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_rdata     (o_rdata),
    .o_err       (o_err),
    .o_mem_req   (o_mem_req),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_be    (o_mem_be),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Reference model: size = funct3 mod 4 (0 byte, 1 half, 2 word)
  function automatic bit m_legal(input bit we, input int f3,
                                 input int unsigned addr);
    bit ok;
    if (we) ok = (f3 <= 2);
    else    ok = (f3 <= 2) || f3 == 4 || f3 == 5;
`ifdef MISALIGN_TRAP_EN
    if (f3 % 4 == 1 && addr % 2 != 0) ok = 0;
    if (f3 % 4 == 2 && addr % 4 != 0) ok = 0;
`endif
    return ok;
  endfunction

  function automatic int unsigned m_be(input bit we, input int f3,
                                       input int unsigned addr);
    if (!we)        return 15;
    if (f3 % 4 == 0) return 1 << (addr % 4);
    if (f3 % 4 == 1) return (addr % 4 >= 2) ? 12 : 3;
    return 15;
  endfunction

  function automatic int unsigned m_wd(input int f3,
                                       input int unsigned wd);
    if (f3 % 4 == 0) return (wd % 256) * 32'h0101_0101;
    if (f3 % 4 == 1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic int unsigned m_rd(input int f3,
                                       input int unsigned addr,
                                       input int unsigned mrd);
    int unsigned v;
    bit sgn;
    sgn = (f3 < 4);
    if (f3 % 4 == 0) begin
      v = (mrd >> (8 * (addr % 4))) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (f3 % 4 == 1) begin
      v = (mrd >> (16 * ((addr / 2) % 2))) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = mrd;
    end
    return v;
  endfunction

  // dly: WAIT cycles before ack (0 = first WAIT cycle), <0 = never
  task automatic access(input string nm, input bit we,
                        input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] wd,
                        input int dly,
                        input logic [31:0] mrd);
    bit ok, eerr, done;
    int lat, nreq, cyc, reqs;
    logic [31:0] ebe, ewd, erd;
    ok  = m_legal(we, int'(f3), addr);
    ebe = m_be(we, int'(f3), addr);
    ewd = m_wd(int'(f3), wd);
    if (!ok) begin
      lat = 1; nreq = 0; eerr = 1; erd = 0;
    end else if (dly < 0 || dly >= TO) begin
      lat = 1 + TO; nreq = TO; eerr = 1; erd = 0;
    end else begin
      lat = 2 + dly; nreq = dly + 1; eerr = 0;
      erd = m_rd(int'(f3), addr, mrd);
    end
    @(negedge clk);
    i_req = 1; i_we = we; i_funct3 = f3;
    i_addr = addr; i_wdata = wd;
    @(negedge clk);
    i_req = 0; i_we = 1'($urandom);
    i_funct3 = 3'($urandom); i_addr = $urandom;
    i_wdata = $urandom;
    check({nm, " busy"}, 32'(o_busy), 32'd1);
    cyc = 1; reqs = 0; done = 0;
    while (!done) begin
      if (o_mem_req) begin
        if (reqs == 0) begin
          check({nm, " addr"}, o_mem_addr, addr & ~32'd3);
          check({nm, " we"}, 32'(o_mem_we), 32'(we));
          check({nm, " be"}, 32'(o_mem_be), ebe);
          if (we) check({nm, " wdata"}, o_mem_wdata, ewd);
        end
        reqs++;
      end
      i_mem_ack   = o_mem_req && dly >= 0 && (reqs - 1) == dly;
      i_mem_rdata = i_mem_ack ? mrd : $urandom;
      if (o_done) done = 1;
      else if (cyc >= 40) begin
        check({nm, " no o_done"}, 32'd0, 32'd1);
        done = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    i_mem_ack = 0;
    check({nm, " latency"}, 32'(cyc), 32'(lat));
    check({nm, " reqs"}, 32'(reqs), 32'(nreq));
    check({nm, " err"}, 32'(o_err), 32'(eerr));
    if (!we || eerr) check({nm, " rdata"}, o_rdata, erd);
    // a request raised during DONE must be dropped
    i_req = 1; i_we = 1'($urandom); i_funct3 = 3'($urandom);
    i_addr = $urandom & ~32'd3;
    @(negedge clk);
    i_req = 0;
    check({nm, " drop busy"}, 32'(o_busy), 32'd0);
    check({nm, " pulse"}, 32'(o_done), 32'd0);
    if (!we || eerr) check({nm, " hold"}, o_rdata, erd);
  endtask

  initial begin
    rst_n = 0; i_req = 0; i_we = 0; i_funct3 = 0;
    i_addr = 0; i_wdata = 0; i_mem_ack = 0; i_mem_rdata = 0;
    #7;
    check("rst ctl",
          32'({o_busy, o_done, o_err, o_mem_req, o_mem_we}), 32'd0);
    check("rst be", 32'(o_mem_be), 32'd0);
    check("rst rdata", o_rdata, 32'd0);
    check("rst addr", o_mem_addr, 32'd0);
    check("rst wdata", o_mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1;

    access("LW", 0, 3'b010, 32'h100, 0, 0, 32'hDEAD_BEEF);
    access("LB", 0, 3'b000, 32'h103, 0, 1, 32'h80FF_FFFF);
    access("LBU", 0, 3'b100, 32'h103, 0, 0, 32'h80FF_FFFF);
    access("LH", 0, 3'b001, 32'h102, 0, 2, 32'h8001_0000);
    access("LHU", 0, 3'b101, 32'h102, 0, 0, 32'h8001_0000);
    access("SB", 1, 3'b000, 32'h202, 32'h1234_5678, 0, 0);
    access("SH", 1, 3'b001, 32'h200, 32'h0000_ABCD, 1, 0);
    access("TMO", 0, 3'b010, 32'h100, 0, -1, 32'h1234_5678);
    access("ACKLAST", 0, 3'b010, 32'h104, 0, TO - 1,
           32'hCAFE_F00D);
    access("ST100", 1, 3'b100, 32'h300, 32'h55, 0, 0);
    access("LD011", 0, 3'b011, 32'h300, 0, 0, 32'h1);
    access("SWMIS", 1, 3'b010, 32'h101, 32'hA5A5_0F0F, 0, 0);

    // reset while waiting on the bus
    @(negedge clk);
    i_req = 1; i_we = 0; i_funct3 = 3'b010; i_addr = 32'h400;
    @(negedge clk);
    i_req = 0;
    check("RST pre req", 32'(o_mem_req), 32'd1);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("RST req drop", 32'(o_mem_req), 32'd0);
    check("RST busy", 32'(o_busy), 32'd0);
    check("RST done", 32'(o_done), 32'd0);
    @(negedge clk);
    check("RST done2", 32'(o_done), 32'd0);
    rst_n = 1;
    repeat (2) begin
      @(negedge clk);
      check("RST no done", 32'(o_done), 32'd0);
    end
    access("LW2", 0, 3'b010, 32'h100, 0, 0, 32'h0BAD_F00D);

    for (int k = 0; k < 80; k++) begin
      int d;
      d = int'($urandom_range(0, 5));
      if (d == 5) d = -1;
      access($sformatf("R%0d", k), 1'($urandom),
             3'($urandom), $urandom, $urandom, d, $urandom);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
